// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic-unit encodings and constants.
package arith_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_CALC = ST_CALC,
        S_DONE = ST_DONE
    } state_e;

    localparam int MAX_WIDTH = 128;

    function automatic logic [MAX_WIDTH-1:0] div0_quot(input int unsigned width);
        return {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
    endfunction

endpackage

// File: rtl/cla.sv
// rtl/cla.sv - carry-lookahead adder, 4-bit lookahead groups chained by group carry.
module cla #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W-1:0] p;
    logic [W-1:0] g;
    logic [W:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    // Bit carries inside a group depend only on the group carry-in.
    always_comb begin
        logic cg;
        logic gr;
        logic pr;
        c    = '0;
        c[0] = ci;
        cg   = ci;
        gr   = 1'b0;
        pr   = 1'b1;
        for (int base = 0; base < W; base += 4) begin
            gr = 1'b0;
            pr = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (base + k < W) begin
                    gr = g[base+k] | (p[base+k] & gr);
                    pr = p[base+k] & pr;
                    c[base+k+1] = gr | (pr & cg);
                end
            end
            cg = gr | (pr & cg);
        end
    end

    assign s  = p ^ c[W-1:0];
    assign co = c[W];

endmodule

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration: WIDTH+1-bit trial subtract and select.
module div_step #(
    parameter int W = 32
) (
    input  logic [W:0]   rem_shift,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);

    logic [W:0] diff;
    logic       no_borrow;

    cla #(.W(W+1)) u_sub (
        .a  (rem_shift),
        .b  (~{1'b0, divisor}),
        .ci (1'b1),
        .s  (diff),
        .co (no_borrow)
    );

    // rem_shift < 2*divisor, so a successful subtract always leaves diff[W] clear.
    assign q_bit    = no_borrow & ~diff[W];
    assign rem_next = q_bit ? diff[W-1:0] : rem_shift[W-1:0];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - radix-2 restoring sequential divider; SEQ_DIVIDER_SIGNED_EN enables two's-complement operands.
module seq_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [WIDTH-1:0] DIV0_Q = WIDTH'(div0_quot(WIDTH));

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] res_quot_q, res_quot_d;
    logic [WIDTH-1:0] res_rem_q, res_rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_bit;
    logic [WIDTH-1:0] quot_step;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] fin_quot;
    logic [WIDTH-1:0] fin_rem;

    div_step #(.W(WIDTH)) u_step (
        .rem_shift ({rem_q, quot_q[WIDTH-1]}),
        .divisor   (dvsr_q),
        .rem_next  (step_rem),
        .q_bit     (step_bit)
    );

    assign quot_step = {quot_q[WIDTH-2:0], step_bit};

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_quot_q, neg_quot_d;
    logic neg_rem_q, neg_rem_d;

    assign a_mag    = dividend[WIDTH-1] ? -dividend : dividend;
    assign b_mag    = divisor[WIDTH-1]  ? -divisor  : divisor;
    // Truncation toward zero: remainder follows the dividend's sign.
    assign fin_quot = neg_quot_q ? -quot_step : quot_step;
    assign fin_rem  = neg_rem_q  ? -step_rem  : step_rem;

    always_comb begin
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        if (state_q == S_IDLE && in_valid) begin
            neg_quot_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_d  = dividend[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
        end
    end
`else
    assign a_mag    = dividend;
    assign b_mag    = divisor;
    assign fin_quot = quot_step;
    assign fin_rem  = step_rem;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        dvsr_d     = dvsr_q;
        res_quot_d = res_quot_q;
        res_rem_d  = res_rem_q;
        dbz_d      = dbz_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (divisor == '0) begin
                        res_quot_d = DIV0_Q;
                        res_rem_d  = dividend;
                        dbz_d      = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        rem_d   = '0;
                        quot_d  = a_mag;
                        dvsr_d  = b_mag;
                        cnt_d   = CNT_W'(WIDTH);
                        dbz_d   = 1'b0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d  = step_rem;
                quot_d = quot_step;
                cnt_d  = cnt_q - CNT_W'(1);
                // Final iteration writes the (sign-corrected) result straight into the output registers.
                if (cnt_q == CNT_W'(1)) begin
                    res_quot_d = fin_quot;
                    res_rem_d  = fin_rem;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            dvsr_q     <= '0;
            res_quot_q <= '0;
            res_rem_q  <= '0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            dvsr_q     <= dvsr_d;
            res_quot_q <= res_quot_d;
            res_rem_q  <= res_rem_d;
            dbz_q      <= dbz_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign quotient    = res_quot_q;
    assign remainder   = res_rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;

    localparam int W      = 32;
    localparam int N_RAND = 800;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           acc;
        int           lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   seen_valid = 0;
    bit   rand_bp = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic z);
        longint qq;
        longint rr;
        if (b == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            qq = longint'($signed(a)) / longint'($signed(b));
            rr = longint'($signed(a)) % longint'($signed(b));
`else
            qq = longint'(a) / longint'(b);
            rr = longint'(a) % longint'(b);
`endif
            q = qq[W-1:0];
            r = rr[W-1:0];
            z = 1'b0;
        end
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp_v);
        end
    endtask

    task automatic send_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (in_ready) begin
                e.q   = eq;
                e.r   = er;
                e.z   = ez;
                e.acc = cyc;
                e.lat = (b == 0) ? 1 : W + 1;
                exp_q.push_back(e);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout: in_ready never seen for 0x%08h/0x%08h", a, b);
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;
        ref_div(a, b, eq, er, ez);
        send_exp(a, b, eq, er, ez);
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL result_timeout: %0d results still outstanding", exp_q.size());
        exp_q.delete();
    endtask

    // Every cycle a result is presented it must match the oldest accepted operation.
    always @(negedge clk) begin
        if (rst) begin
            seen_valid = 0;
        end else if (out_valid) begin
            n_tests++;
            if (in_ready) begin
                n_fail++;
                $display("FAIL ready_with_valid: in_ready=1 while out_valid=1");
            end
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result: q=0x%08h r=0x%08h with nothing outstanding", quotient, remainder);
            end else begin
                if (quotient !== exp_q[0].q || remainder !== exp_q[0].r || div_by_zero !== exp_q[0].z) begin
                    n_fail++;
                    $display("FAIL result: got q=0x%08h r=0x%08h z=%0b, expected q=0x%08h r=0x%08h z=%0b",
                             quotient, remainder, div_by_zero, exp_q[0].q, exp_q[0].r, exp_q[0].z);
                end
                if (!seen_valid) begin
                    seen_valid = 1;
                    n_tests++;
                    if (cyc - exp_q[0].acc != exp_q[0].lat) begin
                        n_fail++;
                        $display("FAIL latency: got %0d cycles, expected %0d", cyc - exp_q[0].acc, exp_q[0].lat);
                    end
                end
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    seen_valid = 0;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] mq;
        logic [W-1:0] mr;
        logic         mz;
        int           sel;
        bit           seen;

        clk       = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_quotient", quotient, '0);
        chk("rst_remainder", remainder, '0);
        chk("rst_div_by_zero", W'(div_by_zero), W'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        ref_div(32'd100, 32'd7, mq, mr, mz);
        chk("model_100_7_q", mq, 32'd14);
        chk("model_100_7_r", mr, 32'd2);
        ref_div(32'h1234_5678, 32'd0, mq, mr, mz);
        chk("model_div0_q", mq, 32'hFFFF_FFFF);
        chk("model_div0_z", W'(mz), W'(1));

        send_exp(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        wait_idle();
        send_exp(32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        wait_idle();
        send_exp(32'd0, 32'd5, 32'd0, 32'd0, 1'b0);
        wait_idle();
`ifdef SEQ_DIVIDER_SIGNED_EN
        send_exp(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        wait_idle();
        send_exp(32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
        wait_idle();
        send_exp(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        wait_idle();
        send_exp(32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 1'b0);
        wait_idle();
`else
        send_exp(32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0);
        wait_idle();
        send_exp(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        wait_idle();
        send_exp(32'd5, 32'hFFFF_FFFF, 32'd0, 32'd5, 1'b0);
        wait_idle();
`endif

        out_ready = 1'b0;
        send_exp(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        seen = 0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk);
            seen = out_valid;
        end
        chk("bp_out_valid_seen", W'(seen), W'(1));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            dividend = 32'd55;
            divisor  = 32'd5;
            @(negedge clk);
            chk("bp_in_ready_low", W'(in_ready), W'(0));
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", W'(in_ready), W'(1));
        chk("bp_release_out_valid", W'(out_valid), W'(0));
        chk("bp_nothing_outstanding", W'(exp_q.size()), W'(0));

        send_exp(32'd1000, 32'd7, 32'd142, 32'd6, 1'b0);
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("abort_in_ready", W'(in_ready), W'(1));
        chk("abort_out_valid", W'(out_valid), W'(0));
        chk("abort_quotient", quotient, '0);
        chk("abort_remainder", remainder, '0);
        chk("abort_div_by_zero", W'(div_by_zero), W'(0));
        send_exp(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
        wait_idle();

        rand_bp = 1;
        for (int n = 0; n < N_RAND; n++) begin
            a   = $urandom;
            sel = $urandom_range(0, 19);
            if (sel == 0) begin
                b = '0;
            end else if (sel < 6) begin
                b = W'($urandom_range(1, 15));
            end else if (sel < 10) begin
                b = $urandom | 32'h8000_0000;
            end else if (sel < 13) begin
                b = $urandom;
                a = a >> $urandom_range(0, 31);
            end else begin
                b = $urandom >> $urandom_range(0, 31);
            end
            send(a, b);
        end
        rand_bp = 0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
